// File: rtl/tdc_meas_ctrl.sv
// tdc_meas_ctrl: sequences one start/stop time-of-flight measurement around
// the TDC datapath, with per-wait timeout and host abort.
module tdc_meas_ctrl #(
    parameter int PULSE_W     = 4,
    parameter int STOP_DELAY  = 100,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             meas_req,
    input  logic             meas_abort,
    input  logic             TDC_stop,
    input  logic             AluTriger,
    input  logic             result_done,
    output logic             start_o,
    output logic             stop_o,
    output logic             read_req,
    output logic             busy,
    output logic             meas_done,
    output logic             timeout_err,
    output logic [2:0]       err_state,
    output logic [CNT_W-1:0] meas_cnt
);

    localparam int TW = $clog2(TIMEOUT_CYC + PULSE_W + STOP_DELAY + 1);
    localparam logic [TW-1:0] PULSE_LAST = TW'(PULSE_W - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(STOP_DELAY - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [3:0] {
        IDLE, START_P, WAIT_T1, RD1, GAP,
        STOP_P, WAIT_T2, RD2, WAIT_RES
    } state_t;

    state_t        state;
    logic [TW-1:0] cnt;
    logic          wait_st;
    logic          event_hit;
    logic [2:0]    code;

    // Every timed wait shares one counter; only the awaited event differs.
    always_comb begin
        wait_st   = 1'b1;
        event_hit = 1'b0;
        code      = 3'd0;
        unique case (state)
            WAIT_T1: begin
                event_hit = TDC_stop;
                code      = 3'd1;
            end
            RD1: begin
                event_hit = AluTriger;
                code      = 3'd2;
            end
            WAIT_T2: begin
                event_hit = TDC_stop;
                code      = 3'd3;
            end
            RD2: begin
                event_hit = AluTriger;
                code      = 3'd4;
            end
            WAIT_RES: begin
                event_hit = result_done;
                code      = 3'd5;
            end
            default: wait_st = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            start_o     <= 1'b0;
            stop_o      <= 1'b0;
            read_req    <= 1'b0;
            busy        <= 1'b0;
            meas_done   <= 1'b0;
            timeout_err <= 1'b0;
            err_state   <= 3'd0;
            meas_cnt    <= '0;
        end else begin
            meas_done   <= 1'b0;
            timeout_err <= 1'b0;
            if (state != IDLE) cnt <= cnt + TW'(1);
            if (state != IDLE && meas_abort) begin
                state    <= IDLE;
                start_o  <= 1'b0;
                stop_o   <= 1'b0;
                read_req <= 1'b0;
                busy     <= 1'b0;
                cnt      <= '0;
            end else if (wait_st && !event_hit && cnt == TMO_LAST) begin
                state       <= IDLE;
                timeout_err <= 1'b1;
                err_state   <= code;
                read_req    <= 1'b0;
                busy        <= 1'b0;
                cnt         <= '0;
            end else begin
                unique case (state)
                    IDLE: if (meas_req) begin
                        state     <= START_P;
                        start_o   <= 1'b1;
                        busy      <= 1'b1;
                        err_state <= 3'd0;
                        cnt       <= '0;
                    end
                    START_P: if (cnt == PULSE_LAST) begin
                        state   <= WAIT_T1;
                        start_o <= 1'b0;
                        cnt     <= '0;
                    end
                    WAIT_T1: if (TDC_stop) begin
                        state    <= RD1;
                        read_req <= 1'b1;
                        cnt      <= '0;
                    end
                    RD1: if (AluTriger) begin
                        read_req <= 1'b0;
                        cnt      <= '0;
                        if (STOP_DELAY == 0) begin
                            state  <= STOP_P;
                            stop_o <= 1'b1;
                        end else begin
                            state <= GAP;
                        end
                    end
                    GAP: if (cnt == GAP_LAST) begin
                        state  <= STOP_P;
                        stop_o <= 1'b1;
                        cnt    <= '0;
                    end
                    STOP_P: if (cnt == PULSE_LAST) begin
                        state  <= WAIT_T2;
                        stop_o <= 1'b0;
                        cnt    <= '0;
                    end
                    WAIT_T2: if (TDC_stop) begin
                        state    <= RD2;
                        read_req <= 1'b1;
                        cnt      <= '0;
                    end
                    RD2: if (AluTriger) begin
                        state    <= WAIT_RES;
                        read_req <= 1'b0;
                        cnt      <= '0;
                    end
                    WAIT_RES: if (result_done) begin
                        state     <= IDLE;
                        meas_done <= 1'b1;
                        busy      <= 1'b0;
                        meas_cnt  <= meas_cnt + CNT_W'(1);
                        cnt       <= '0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Bench for tdc_meas_ctrl: per-measurement timeline model built from phase
// durations, checked every cycle, plus directed literal checks.
module tb_tdc_meas_ctrl;

    localparam int P   = 4;
    localparam int D   = 100;
    localparam int T   = 50;
    localparam int CW  = 2;
    localparam int BIG = 1 << 28;

    logic          clk;
    logic          reset_n;
    logic          meas_req;
    logic          meas_abort;
    logic          TDC_stop;
    logic          AluTriger;
    logic          result_done;
    logic          start_o;
    logic          stop_o;
    logic          read_req;
    logic          busy;
    logic          meas_done;
    logic          timeout_err;
    logic [2:0]    err_state;
    logic [CW-1:0] meas_cnt;

    tdc_meas_ctrl #(
        .PULSE_W(P),
        .STOP_DELAY(D),
        .TIMEOUT_CYC(T),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .meas_req(meas_req),
        .meas_abort(meas_abort),
        .TDC_stop(TDC_stop),
        .AluTriger(AluTriger),
        .result_done(result_done),
        .start_o(start_o),
        .stop_o(stop_o),
        .read_req(read_req),
        .busy(busy),
        .meas_done(meas_done),
        .timeout_err(timeout_err),
        .err_state(err_state),
        .meas_cnt(meas_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int  d[5];
    int  m_cnt = 0;
    int  m_err = 0;
    bit  chk_en = 0;
    bit  e_start, e_stop, e_rd, e_busy, e_done, e_terr;
    int  e_err, e_cnt;

    int  cyc = 0;
    int  t_sr, t_sf, t_pr, t_pf, t_rf1, t_done, t_to = -1;
    bit  rf_seen, p_start, p_stop, p_rd;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic bit inw(input int t, input int lo, input int hi);
        return t >= lo && t < hi;
    endfunction

    // Compare process: DUT outputs against the model, every cycle.
    always @(posedge clk) begin
        #2;
        cyc++;
        if (chk_en) begin
            chk("start_o", int'(start_o), int'(e_start));
            chk("stop_o", int'(stop_o), int'(e_stop));
            chk("read_req", int'(read_req), int'(e_rd));
            chk("busy", int'(busy), int'(e_busy));
            chk("meas_done", int'(meas_done), int'(e_done));
            chk("timeout_err", int'(timeout_err), int'(e_terr));
            chk("err_state", int'(err_state), e_err);
            chk("meas_cnt", int'(meas_cnt), e_cnt);
        end
        if (start_o && !p_start) begin
            t_sr    = cyc;
            rf_seen = 0;
        end
        if (!start_o && p_start) t_sf = cyc;
        if (stop_o && !p_stop) t_pr = cyc;
        if (!stop_o && p_stop) t_pf = cyc;
        if (!read_req && p_rd && !rf_seen) begin
            t_rf1   = cyc;
            rf_seen = 1;
        end
        if (meas_done) t_done = cyc;
        if (timeout_err) t_to = cyc;
        p_start = start_o;
        p_stop  = stop_o;
        p_rd    = read_req;
    end

    task automatic idle(input int n, input bit noise);
        for (int i = 0; i < n; i++) begin
            meas_req    = 1'b0;
            meas_abort  = noise && ($urandom_range(0, 3) == 0);
            TDC_stop    = noise && ($urandom_range(0, 3) == 0);
            AluTriger   = noise && ($urandom_range(0, 3) == 0);
            result_done = noise && ($urandom_range(0, 3) == 0);
            {e_start, e_stop, e_rd, e_busy, e_done, e_terr} = '0;
            e_err  = m_err;
            e_cnt  = m_cnt;
            chk_en = 1;
            @(negedge clk);
        end
    endtask

    // Step 0 drives the request; step u output expectations follow from
    // the phase durations d[] laid end to end.
    task automatic run_meas(input int abort_in, input int rst_at,
                            input bit noise);
        int en[5];
        int xt[5];
        int cur, nat_end, code, s_lo, e_end, ab_at, u;
        bit tmo, ab, live, done_u, terr_u;
        for (int k = 0; k < 5; k++) begin
            en[k] = BIG;
            xt[k] = BIG;
        end
        s_lo = BIG;
        code = 0;
        tmo  = 0;
        cur  = P + 1;
        for (int k = 0; k < 5; k++) begin
            if (!tmo) begin
                en[k] = cur;
                if (d[k] >= T) begin
                    tmo   = 1;
                    code  = k + 1;
                    cur   = cur + T;
                    xt[k] = cur;
                end else begin
                    cur   = cur + d[k] + 1;
                    xt[k] = cur;
                    if (k == 1) begin
                        s_lo = cur + D;
                        cur  = s_lo + P;
                    end
                end
            end
        end
        nat_end = cur;
        ab_at = abort_in;
        if (abort_in == -2)
            ab_at = ($urandom_range(0, 3) == 0) ? nat_end - 1
                    : int'($urandom_range(1, nat_end - 1));
        ab = ab_at >= 1 && ab_at < nat_end;
        e_end = ab ? ab_at + 1 : nat_end;
        for (int t = 0; t < e_end; t++) begin
            if (t == rst_at) begin
                chk_en      = 0;
                meas_req    = 1'b0;
                meas_abort  = 1'b0;
                TDC_stop    = 1'b0;
                AluTriger   = 1'b0;
                result_done = 1'b0;
                #1;
                chk("pre_rst_read_req", int'(read_req), 1);
                reset_n = 1'b0;
                #1;
                chk("rst_start_o", int'(start_o), 0);
                chk("rst_stop_o", int'(stop_o), 0);
                chk("rst_read_req", int'(read_req), 0);
                chk("rst_busy", int'(busy), 0);
                chk("rst_meas_done", int'(meas_done), 0);
                chk("rst_timeout_err", int'(timeout_err), 0);
                chk("rst_err_state", int'(err_state), 0);
                chk("rst_meas_cnt", int'(meas_cnt), 0);
                m_cnt = 0;
                m_err = 0;
                @(negedge clk);
                reset_n = 1'b1;
                return;
            end
            meas_req   = (t == 0) || ($urandom_range(0, 15) == 0);
            meas_abort = (ab && t == ab_at) ||
                         (noise && t == 0 && $urandom_range(0, 7) == 0);
            TDC_stop = (d[0] < T && t == en[0] + d[0]) ||
                       (d[2] < T && t == en[2] + d[2]) ||
                       (noise && !inw(t, en[0], xt[0]) &&
                        !inw(t, en[2], xt[2]) &&
                        $urandom_range(0, 7) == 0);
            AluTriger = (d[1] < T && t == en[1] + d[1]) ||
                        (d[3] < T && t == en[3] + d[3]) ||
                        (noise && !inw(t, en[1], xt[1]) &&
                         !inw(t, en[3], xt[3]) &&
                         $urandom_range(0, 7) == 0);
            result_done = (d[4] < T && t == en[4] + d[4]) ||
                          (noise && !inw(t, en[4], xt[4]) &&
                           $urandom_range(0, 7) == 0);
            u      = t + 1;
            live   = u < e_end;
            done_u = !ab && !tmo && u == nat_end;
            terr_u = !ab && tmo && u == nat_end;
            if (done_u) m_cnt = (m_cnt + 1) % (1 << CW);
            m_err   = terr_u ? code : 0;
            e_start = live && u <= P;
            e_stop  = live && inw(u, s_lo, s_lo + P);
            e_rd    = live && (inw(u, en[1], xt[1]) || inw(u, en[3], xt[3]));
            e_busy  = live;
            e_done  = done_u;
            e_terr  = terr_u;
            e_err   = m_err;
            e_cnt   = m_cnt;
            chk_en  = 1;
            @(negedge clk);
        end
    endtask

    int to_save;

    initial begin
        reset_n     = 1'b0;
        meas_req    = 1'b0;
        meas_abort  = 1'b0;
        TDC_stop    = 1'b0;
        AluTriger   = 1'b0;
        result_done = 1'b0;
        #3;
        chk("reset_start_o", int'(start_o), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_err_state", int'(err_state), 0);
        chk("reset_meas_cnt", int'(meas_cnt), 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        idle(3, 0);

        // Normal measurement with hand-computed timeline.
        d = '{10, 5, 10, 5, 3};
        run_meas(-1, -1, 0);
        chk("normal_start_width", t_sf - t_sr, 4);
        chk("normal_gap", t_pr - t_rf1, 100);
        chk("normal_done_time", t_done - t_sr, 146);
        chk("normal_meas_cnt", int'(meas_cnt), 1);
        idle(2, 0);

        // Timeout in WAIT_T1.
        d = '{50, 0, 0, 0, 0};
        run_meas(-1, -1, 0);
        chk("timeout_time", t_to - t_sf, 50);
        chk("timeout_err_state", int'(err_state), 1);
        chk("timeout_busy", int'(busy), 0);
        chk("timeout_meas_cnt", int'(meas_cnt), 1);
        idle(2, 0);

        // AluTriger in the RD2 expiry cycle.
        to_save = t_to;
        d = '{3, 2, 4, 49, 1};
        run_meas(-1, -1, 0);
        chk("race_no_timeout", t_to, to_save);
        chk("race_meas_cnt", int'(meas_cnt), 2);
        chk("race_err_cleared", int'(err_state), 0);
        idle(2, 0);

        // Abort during the second STOP_P cycle (stop_o rises at step 122).
        d = '{10, 5, 10, 5, 3};
        run_meas(123, -1, 0);
        chk("abort_stop_width", t_pf - t_pr, 2);
        chk("abort_busy", int'(busy), 0);
        chk("abort_meas_cnt", int'(meas_cnt), 2);
        idle(2, 0);
        run_meas(-1, -1, 0);
        chk("after_abort_cnt", int'(meas_cnt), 3);
        idle(1, 0);
        run_meas(-1, -1, 0);
        chk("wrap_cnt", int'(meas_cnt), 0);
        idle(1, 0);
        run_meas(-1, -1, 0);
        chk("post_wrap_cnt", int'(meas_cnt), 1);
        idle(1, 0);

        // Asynchronous reset while read 1 is pending.
        run_meas(-1, 18, 0);
        idle(3, 0);
        run_meas(-1, -1, 0);
        chk("post_reset_cnt", int'(meas_cnt), 1);
        idle(2, 0);

        for (int i = 0; i < 60; i++) begin
            for (int k = 0; k < 5; k++) begin
                int r;
                r = int'($urandom_range(0, 99));
                if (r < 4) d[k] = T;
                else if (r < 12) d[k] = T - 1;
                else d[k] = int'($urandom_range(0, 15));
            end
            run_meas(($urandom_range(0, 5) == 0) ? -2 : -1, -1, 1);
            idle(int'($urandom_range(0, 3)), 1);
        end
        idle(2, 0);
        chk_en = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
